// File: rtl/ras_fifo_ctrl_if.sv
// Bundled requester, consumer and ras_fifo-side signals of the return-address FIFO controller.
// The controller takes the slave modport; the environment (requesters, consumer, FIFO) takes master.
interface ras_fifo_ctrl_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
);
  localparam int ID_W   = $clog2(N_REQ);
  localparam int FIFO_W = DATA_W + ID_W;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic                    flush;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    out_valid;
  logic [DATA_W-1:0]       out_data;
  logic [ID_W-1:0]         out_id;
  logic                    out_ready;
  logic                    fifo_rst;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic [FIFO_W-1:0]       fifo_din;
  logic [FIFO_W-1:0]       fifo_dout;
  logic                    fifo_empty;
  logic [CNT_W-1:0]        count;
  logic                    full;
  logic                    busy;
  logic                    err;

  modport slave (
    input  flush, req_valid, req_data, out_ready, fifo_dout, fifo_empty,
    output req_ready, out_valid, out_data, out_id,
           fifo_rst, fifo_push, fifo_pop, fifo_din,
           count, full, busy, err
  );

  modport master (
    output flush, req_valid, req_data, out_ready, fifo_dout, fifo_empty,
    input  req_ready, out_valid, out_data, out_id,
           fifo_rst, fifo_push, fifo_pop, fifo_din,
           count, full, busy, err
  );
endinterface

// File: rtl/ras_fifo_ctrl.sv
// Round-robin push arbiter, pop handshake and flush sequencer in front of ras_fifo.
//   state | meaning
//   RUN   | normal operation: arbitrate pushes, serve pops, track occupancy
//   FLUSH | one-cycle FIFO reset; no handshakes, count cleared
module ras_fifo_ctrl #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input logic            clk,
  input logic            rst,
  ras_fifo_ctrl_if.slave bus
);
  localparam int ID_W   = $clog2(N_REQ);
  localparam int FIFO_W = DATA_W + ID_W;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   last_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              err_q;

  logic              run;
  logic              full;
  logic              accept;
  logic              found;
  logic [ID_W-1:0]   winner;
  logic [DATA_W-1:0] payload;
  logic              grant;
  logic              push;
  logic              pop;
  logic              out_valid;

  assign run    = (state_q == RUN);
  assign full   = (count_q == CNT_W'(DEPTH));
  assign accept = run && !full;

  // First valid requester after the previous winner, wrapping at N_REQ.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_q) + k) % N_REQ;
      if (!found && bus.req_valid[idx]) begin
        found  = 1'b1;
        winner = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    payload = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner == ID_W'(i)) payload = bus.req_data[i*DATA_W +: DATA_W];
    end
  end

  assign grant = accept && found;

  always_comb begin
    bus.req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      bus.req_ready[i] = grant && (winner == ID_W'(i));
    end
  end

  assign push      = |(bus.req_valid & bus.req_ready);
  assign out_valid = run && (count_q != '0);
  assign pop       = out_valid && bus.out_ready;

  assign bus.fifo_push = push;
  assign bus.fifo_pop  = pop;
  assign bus.fifo_din  = {winner, payload};
  assign bus.out_valid = out_valid;
  assign bus.out_data  = bus.fifo_dout[DATA_W-1:0];
  assign bus.out_id    = bus.fifo_dout[FIFO_W-1 -: ID_W];
  assign bus.fifo_rst  = rst || (state_q == FLUSH);
  assign bus.busy      = (state_q == FLUSH);
  assign bus.count     = count_q;
  assign bus.full      = full;
  assign bus.err       = err_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= FLUSH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (bus.flush) state_d = FLUSH;
      FLUSH:   state_d = RUN;
      default: state_d = FLUSH;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (!run)            count_d = '0;
    else if (push && !pop) count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      last_q  <= ID_W'(N_REQ - 1);
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      if (grant) last_q <= winner;
      // The FIFO's own empty flag must agree with our occupancy; sticky until rst.
      if (run && (bus.fifo_empty != (count_q == '0))) err_q <= 1'b1;
    end
  end
endmodule
